// File: rtl/mult_div_scheduler.sv
`default_nettype none
// mult_div_scheduler: multi-cycle HI/LO multiply/divide unit with E-stage stall control.
// Results are computed at the accepting edge into pending registers and committed on completion.
module mult_div_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        read_req_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) > 5) ? $clog2(MAXC + 1) : 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     hi_q, lo_q, phi_q, plo_q;

    logic            sgn_d, a_neg_d, b_neg_d;
    logic [63:0]     ext_a_d, ext_b_d, mul_d;
    logic [31:0]     mag_a_d, mag_b_d, uq_d, ur_d, quo_d, rem_d;

    // Signed divide works on magnitudes so the INT_MIN / -1 case needs no special path.
    always_comb begin
        sgn_d   = (op_i == OP_MULT) || (op_i == OP_DIV);
        ext_a_d = sgn_d ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
        ext_b_d = sgn_d ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
        mul_d   = ext_a_d * ext_b_d;
        a_neg_d = sgn_d & a_i[31];
        b_neg_d = sgn_d & b_i[31];
        mag_a_d = a_neg_d ? (32'd0 - a_i) : a_i;
        mag_b_d = b_neg_d ? (32'd0 - b_i) : b_i;
        if (mag_b_d == 32'd0) begin
            uq_d = 32'd0;
            ur_d = 32'd0;
        end else begin
            uq_d = mag_a_d / mag_b_d;
            ur_d = mag_a_d % mag_b_d;
        end
        if (b_i == 32'd0) begin
            quo_d = 32'hFFFF_FFFF;
            rem_d = a_i;
        end else begin
            quo_d = (a_neg_d ^ b_neg_d) ? (32'd0 - uq_d) : uq_d;
            rem_d = a_neg_d ? (32'd0 - ur_d) : ur_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !cancel_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU: begin
                                state_q        <= S_MUL;
                                cnt_q          <= CW'(MULT_CYCLES - 1);
                                {phi_q, plo_q} <= mul_d;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_q <= S_DIV;
                                cnt_q   <= CW'(DIV_CYCLES - 1);
                                phi_q   <= rem_d;
                                plo_q   <= quo_d;
                            end
                            OP_MTHI: hi_q <= a_i;
                            OP_MTLO: lo_q <= a_i;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (cancel_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        hi_q    <= phi_q;
                        lo_q    <= plo_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
            endcase
        end
    end

    // done is suppressed by a same-cycle cancel, so it cannot be a pure flop.
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = busy_o && (cnt_q == '0) && !cancel_i;
    assign stall_o = busy_o && (start_i || read_req_i);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_scheduler.sv
`default_nettype none
// tb_mult_div_scheduler: randomized scoreboard bench; a monitor pops expected HI/LO after each done.
module tb_mult_div_scheduler;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, read_req, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] sb[$];
    logic [31:0] mhi, mlo;
    logic        pend = 1'b0;

    mult_div_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .read_req_i(read_req), .cancel_i(cancel), .busy_o(busy), .stall_o(stall),
        .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o >= 3'd2 && y == 32'd0) return {x, 32'hFFFF_FFFF};
        case (o)
            3'd0: return sx * sy;
            3'd1: return ux * uy;
            3'd2: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: return {32'(ux % uy), 32'(ux / uy)};
        endcase
    endfunction

    always @(negedge clk) begin
        logic [63:0] e;
        if (pend) begin
            pend = 1'b0;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result hi", 64'(hi), 64'(e[63:32]));
                chk("result lo", 64'(lo), 64'(e[31:0]));
                mhi = e[63:32];
                mlo = e[31:0];
            end
        end
        if (done) begin
            chk("done has pending expectation", 64'(sb.size() != 0), 64'(1));
            pend = 1'b1;
        end
    end

    // Issues one op from IDLE and checks busy/done/stall timing; results go through the scoreboard.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic rd);
        int n, nb, nd, dpos;
        start = 1'b1; op = o; a = x; b = y; read_req = rd;
        n = (o < 3'd2) ? MC : DC;
        if (o < 3'd4) sb.push_back(ref_op(o, x, y));
        step();
        start = 1'b0;
        a = ~x;
        b = y ^ 32'h5A5A_A5A5;
        if (o >= 3'd4) begin
            if (o == 3'd4) mhi = x;
            if (o == 3'd5) mlo = x;
            @(negedge clk);
            chk("no busy for MT/reserved", 64'(busy), 64'(0));
            if (rd) chk("no stall in idle", 64'(stall), 64'(0));
            chk("hi after MT/reserved", 64'(hi), 64'(mhi));
            chk("lo after MT/reserved", 64'(lo), 64'(mlo));
            read_req = 1'b0;
            step();
            return;
        end
        nb = 0; nd = 0; dpos = 0;
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                dpos = c;
            end
            if (rd) chk("stall window", 64'(stall), 64'(c <= n));
            if (!busy) break;
            @(posedge clk);
        end
        read_req = 1'b0;
        chk("busy cycle count", 64'(nb), 64'(n));
        chk("done position", 64'(dpos), 64'(n));
        chk("done pulse count", 64'(nd), 64'(1));
        step();
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle reached", 64'(busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y, x2, y2;
        logic [2:0]  o;
        int          sel;
        rst_n = 1'b0; start = 1'b0; read_req = 1'b1; cancel = 1'b0;
        op = 3'd0; a = '0; b = '0; mhi = '0; mlo = '0;
        #12;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset stall", 64'(stall), 64'(0));
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset lo", 64'(lo), 64'(0));
        read_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op(3'd5, 32'h1234, 32'd0, 1'b0);
        chk("MTLO lo", 64'(lo), 64'h1234);
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("MULT -2*3 hi", 64'(hi), 64'hFFFF_FFFF);
        chk("MULT -2*3 lo", 64'(lo), 64'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("DIV -7/2 lo", 64'(lo), 64'hFFFF_FFFD);
        chk("DIV -7/2 hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(3'd2, 32'd5, 32'd0, 1'b0);
        chk("DIV 5/0 lo", 64'(lo), 64'hFFFF_FFFF);
        chk("DIV 5/0 hi", 64'(hi), 64'd5);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("DIV overflow lo", 64'(lo), 64'h8000_0000);
        chk("DIV overflow hi", 64'(hi), 64'd0);

        // Second start arriving mid-MULT is held under stall and taken once idle.
        x = $urandom; y = $urandom; x2 = $urandom; y2 = $urandom;
        start = 1'b1; op = 3'd0; a = x; b = y;
        sb.push_back(ref_op(3'd0, x, y));
        step();
        start = 1'b0;
        step();
        start = 1'b1; op = 3'd1; a = x2; b = y2;
        for (int c = 2; c <= MC; c++) begin
            @(negedge clk);
            chk("stall on held start", 64'(stall), 64'(1));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("no stall once idle", 64'(stall), 64'(0));
        chk("idle before held start", 64'(busy), 64'(0));
        sb.push_back(ref_op(3'd1, x2, y2));
        step();
        start = 1'b0;
        @(negedge clk);
        chk("held start accepted", 64'(busy), 64'(1));
        wait_idle();
        step();

        // Cancel in cycle 3 and in the last busy cycle of a DIV.
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; op = 3'd2; a = $urandom; b = $urandom_range(1, 1000);
            step();
            start = 1'b0;
            for (int c = 2; c <= ((k == 0) ? 3 : DC); c++) step();
            cancel = 1'b1;
            @(negedge clk);
            chk("busy during cancel", 64'(busy), 64'(1));
            chk("no done on cancel", 64'(done), 64'(0));
            step();
            cancel = 1'b0;
            @(negedge clk);
            chk("idle after cancel", 64'(busy), 64'(0));
            chk("hi kept on cancel", 64'(hi), 64'(mhi));
            chk("lo kept on cancel", 64'(lo), 64'(mlo));
            step();
        end

        start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("start ignored with cancel", 64'(lo), 64'(mlo));
        chk("no busy with cancel", 64'(busy), 64'(0));
        step();

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom; y = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) y = 32'd0;
            if (sel == 1) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end
            if (sel == 2 || sel == 3) y = $urandom_range(1, 20);
            run_op(o, x, y, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset during a MULT.
        read_req = 1'b1;
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
        step();
        start = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset busy", 64'(busy), 64'(0));
        chk("async reset done", 64'(done), 64'(0));
        chk("async reset stall", 64'(stall), 64'(0));
        chk("async reset hi", 64'(hi), 64'(0));
        chk("async reset lo", 64'(lo), 64'(0));
        mhi = '0; mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd3, 32'd100, 32'd7, 1'b1);
        chk("DIVU 100/7 lo", 64'(lo), 64'd14);
        chk("DIVU 100/7 hi", 64'(hi), 64'd2);

        repeat (3) step();
        chk("scoreboard drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
